// File: rtl/gcd_client.sv
// gcd_client: host-side initiator for the 4-bit GCD unit.
// Buffers operand pairs in a small FIFO, hands each pair to the GCD unit
// over its ready/enable ports, and returns each result as a held beat.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no job in flight; pops the FIFO head when one is available
// SEND_A | presenting operand A, strobe follows a_rdy_i
// SEND_B | presenting operand B, strobe follows b_rdy_i
// WAIT_Y | waiting for y_rdy_i, abandons the job after TIMEOUT cycles
// OUT    | result beat held until downstream takes it
module gcd_client #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       cmd_valid_i,
  input  logic [3:0] cmd_a_i,
  input  logic [3:0] cmd_b_i,
  output logic       cmd_ready_o,
  output logic [3:0] a_data_o,
  output logic [3:0] b_data_o,
  output logic       a_en_o,
  output logic       b_en_o,
  output logic       y_en_o,
  input  logic       a_rdy_i,
  input  logic       b_rdy_i,
  input  logic       y_rdy_i,
  input  logic [3:0] y_data_i,
  output logic       res_valid_o,
  output logic [3:0] res_a_o,
  output logic [3:0] res_b_o,
  output logic [3:0] res_y_o,
  input  logic       res_ready_i,
  output logic       timeout_o,
  output logic [7:0] done_cnt_o,
  output logic       busy_o
);

  localparam int AW = $clog2(DEPTH);
  // One extra bit so TIMEOUT itself is representable even when it is a power of two.
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEND_A = 3'd1,
    SEND_B = 3'd2,
    WAIT_Y = 3'd3,
    OUT    = 3'd4
  } state_t;

  state_t        state;

  logic [3:0]    mem_a [DEPTH];
  logic [3:0]    mem_b [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;

  logic [3:0]    ja;
  logic [3:0]    jb;
  logic [3:0]    a_data_q;
  logic [3:0]    b_data_q;
  logic [TW-1:0] t_cnt;
  logic [3:0]    res_a_q;
  logic [3:0]    res_b_q;
  logic [3:0]    res_y_q;
  logic          res_valid_q;
  logic          timeout_q;
  logic [7:0]    done_cnt_q;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign push  = cmd_valid_i && !full;
  assign pop   = (state == IDLE) && !empty;

  // FIFO storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_a[wr_ptr] <= cmd_a_i;
      mem_b[wr_ptr] <= cmd_b_i;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Job sequencing FSM with its data and status registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      ja          <= '0;
      jb          <= '0;
      a_data_q    <= '0;
      b_data_q    <= '0;
      t_cnt       <= '0;
      res_a_q     <= '0;
      res_b_q     <= '0;
      res_y_q     <= '0;
      res_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      done_cnt_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            ja       <= mem_a[rd_ptr];
            jb       <= mem_b[rd_ptr];
            // A bus is loaded on entry so it already shows the operand in SEND_A
            a_data_q <= mem_a[rd_ptr];
            state    <= SEND_A;
          end
        end
        SEND_A: begin
          if (a_rdy_i) begin
            b_data_q <= jb;
            state    <= SEND_B;
          end
        end
        SEND_B: begin
          if (b_rdy_i) begin
            t_cnt <= '0;
            state <= WAIT_Y;
          end
        end
        WAIT_Y: begin
          if (y_rdy_i) begin
            res_y_q     <= y_data_i;
            res_a_q     <= ja;
            res_b_q     <= jb;
            res_valid_q <= 1'b1;
            state       <= OUT;
          end else if (t_cnt == TW'(TIMEOUT - 1)) begin
            // Job is dropped silently apart from the sticky flag
            timeout_q <= 1'b1;
            state     <= IDLE;
          end else begin
            t_cnt <= t_cnt + 1'b1;
          end
        end
        OUT: begin
          if (res_ready_i) begin
            res_valid_q <= 1'b0;
            done_cnt_q  <= done_cnt_q + 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes follow the GCD unit's ready inputs so a handshake never waits a cycle
  assign a_en_o      = (state == SEND_A) && a_rdy_i;
  assign b_en_o      = (state == SEND_B) && b_rdy_i;
  assign y_en_o      = (state == WAIT_Y) && y_rdy_i;

  assign cmd_ready_o = !full;
  assign a_data_o    = a_data_q;
  assign b_data_o    = b_data_q;
  assign res_valid_o = res_valid_q;
  assign res_a_o     = res_a_q;
  assign res_b_o     = res_b_q;
  assign res_y_o     = res_y_q;
  assign timeout_o   = timeout_q;
  assign done_cnt_o  = done_cnt_q;
  assign busy_o      = (state != IDLE) || !empty;

endmodule

// File: tb/tb_gcd_client.sv
// tb_gcd_client: directed bench for gcd_client with a behavioural GCD responder.
module tb_gcd_client;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid_i;
  logic [3:0] cmd_a_i;
  logic [3:0] cmd_b_i;
  logic       cmd_ready_o;
  logic [3:0] a_data_o;
  logic [3:0] b_data_o;
  logic       a_en_o;
  logic       b_en_o;
  logic       y_en_o;
  logic       a_rdy_i;
  logic       b_rdy_i;
  logic       y_rdy_i;
  logic [3:0] y_data_i;
  logic       res_valid_o;
  logic [3:0] res_a_o;
  logic [3:0] res_b_o;
  logic [3:0] res_y_o;
  logic       res_ready_i;
  logic       timeout_o;
  logic [7:0] done_cnt_o;
  logic       busy_o;

  gcd_client #(.DEPTH(4), .TIMEOUT(64)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .cmd_valid_i(cmd_valid_i),
    .cmd_a_i    (cmd_a_i),
    .cmd_b_i    (cmd_b_i),
    .cmd_ready_o(cmd_ready_o),
    .a_data_o   (a_data_o),
    .b_data_o   (b_data_o),
    .a_en_o     (a_en_o),
    .b_en_o     (b_en_o),
    .y_en_o     (y_en_o),
    .a_rdy_i    (a_rdy_i),
    .b_rdy_i    (b_rdy_i),
    .y_rdy_i    (y_rdy_i),
    .y_data_i   (y_data_i),
    .res_valid_o(res_valid_o),
    .res_a_o    (res_a_o),
    .res_b_o    (res_b_o),
    .res_y_o    (res_y_o),
    .res_ready_i(res_ready_i),
    .timeout_o  (timeout_o),
    .done_cnt_o (done_cnt_o),
    .busy_o     (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] gcd4(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] p;
    logic [3:0] q;
    logic [3:0] t;
    p = x;
    q = y;
    for (int i = 0; i < 16 && q != 0; i++) begin
      t = p % q;
      p = q;
      q = t;
    end
    return p;
  endfunction

  // Monitor: strobe counts, timestamps and accepted result beats
  int a_cnt = 0, b_cnt = 0, y_cnt = 0, overlap = 0;
  int a_t, b_t, y_t, r_t, to_t;
  bit to_seen = 0;
  bit rv_prev = 0;
  logic [3:0]  a_last;
  logic [11:0] results[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (a_en_o) begin a_cnt++; a_t = cyc; a_last = a_data_o; end
      if (b_en_o) begin b_cnt++; b_t = cyc; end
      if (y_en_o) begin y_cnt++; y_t = cyc; end
      if (int'(a_en_o) + int'(b_en_o) + int'(y_en_o) > 1) overlap++;
      if (res_valid_o && !rv_prev) r_t = cyc;
      if (res_valid_o && res_ready_i) results.push_back({res_a_o, res_b_o, res_y_o});
      if (timeout_o && !to_seen) begin to_seen = 1; to_t = cyc; end
    end
    rv_prev = res_valid_o;
  end

  // GCD responder: raises y_rdy y_delay cycles after the B handshake
  int  y_delay = 1;
  bit  y_hold  = 0;
  int  rn;
  initial begin
    y_rdy_i  = 1'b0;
    y_data_i = 4'd0;
    forever begin
      @(negedge clk);
      if (rst_n && b_en_o && !y_hold) begin
        y_data_i = gcd4(a_last, b_data_o);
        repeat (y_delay) @(posedge clk);
        #1 y_rdy_i = 1'b1;
        rn = 0;
        do begin
          @(negedge clk);
          rn++;
        end while (!y_en_o && rn < 300);
        @(posedge clk);
        #1 y_rdy_i = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] a, input logic [3:0] b);
    int n;
    n = 0;
    cmd_valid_i = 1'b1;
    cmd_a_i     = a;
    cmd_b_i     = b;
    while (!cmd_ready_o && n < 200) begin
      tick();
      n++;
    end
    chk("push_accept", n < 200, 1);
    tick();
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int n;
    n = 0;
    while (busy_o && n < limit) begin
      tick();
      n++;
    end
    chk(tag, busy_o, 0);
  endtask

  task automatic wait_b(input int b0);
    int n;
    n = 0;
    while (b_cnt <= b0 && n < 100) begin
      tick();
      n++;
    end
    chk("b_handshake_seen", b_cnt > b0, 1);
  endtask

  logic [11:0] full_exp [5];
  int a0, b0, y0, d0, bt;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_a_i     = 4'd0;
    cmd_b_i     = 4'd0;
    a_rdy_i     = 1'b1;
    b_rdy_i     = 1'b1;
    res_ready_i = 1'b0;
    repeat (3) tick();

    // Reset values
    chk("rst_cmd_ready", cmd_ready_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_res_valid", res_valid_o, 0);
    chk("rst_timeout", timeout_o, 0);
    chk("rst_done_cnt", done_cnt_o, 0);
    chk("rst_a_data", a_data_o, 0);
    rst_n = 1'b1;
    tick();

    // Single job (12,8) -> 4, y_rdy three cycles after B
    res_ready_i = 1'b1;
    y_delay     = 3;
    results.delete();
    push(4'd12, 4'd8);
    wait_idle("single_idle", 50);
    chk("single_a_cnt", a_cnt, 1);
    chk("single_b_cnt", b_cnt, 1);
    chk("single_y_cnt", y_cnt, 1);
    chk("single_b_after_a", b_t - a_t, 1);
    chk("single_y_after_b", y_t - b_t, 3);
    chk("single_res_after_y", r_t - y_t, 1);
    chk("single_nres", results.size(), 1);
    if (results.size() > 0) chk("single_res", results[0], {4'd12, 4'd8, 4'd4});
    chk("single_done_cnt", done_cnt_o, 1);

    // Backpressure on a_rdy
    y_delay = 1;
    a0 = a_cnt; b0 = b_cnt; y0 = y_cnt;
    results.delete();
    a_rdy_i = 1'b0;
    push(4'd5, 4'd10);
    for (int i = 0; i < 6; i++) begin
      tick();
      #1 chk("bp_a_en_low", a_en_o, 0);
    end
    a_rdy_i = 1'b1;
    #1 chk("bp_a_en_rise", a_en_o, 1);
    wait_idle("bp_idle", 50);
    chk("bp_a_cnt", a_cnt - a0, 1);
    chk("bp_b_cnt", b_cnt - b0, 1);
    chk("bp_y_cnt", y_cnt - y0, 1);
    chk("bp_nres", results.size(), 1);
    if (results.size() > 0) chk("bp_res", results[0], {4'd5, 4'd10, 4'd5});
    chk("bp_done_cnt", done_cnt_o, 2);

    // FIFO full: four buffered plus one held in OUT
    full_exp[0] = {4'd9,  4'd6,  4'd3};
    full_exp[1] = {4'd7,  4'd5,  4'd1};
    full_exp[2] = {4'd15, 4'd10, 4'd5};
    full_exp[3] = {4'd8,  4'd4,  4'd4};
    full_exp[4] = {4'd0,  4'd3,  4'd3};
    results.delete();
    res_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) push(full_exp[i][11:8], full_exp[i][7:4]);
    chk("full_cmd_ready", cmd_ready_o, 0);
    cmd_valid_i = 1'b1;
    cmd_a_i     = 4'd6;
    cmd_b_i     = 4'd4;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("full_cmd_ready_hold", cmd_ready_o, 0);
    end
    cmd_valid_i = 1'b0;
    chk("full_res_valid", res_valid_o, 1);
    chk("full_res_a_held", res_a_o, 9);
    chk("full_res_y_held", res_y_o, 3);
    res_ready_i = 1'b1;
    wait_idle("full_idle", 100);
    chk("full_nres", results.size(), 5);
    for (int i = 0; i < 5 && i < results.size(); i++) chk("full_res_order", results[i], full_exp[i]);
    chk("full_done_cnt", done_cnt_o, 7);

    // Timeout: first job never gets y_rdy, second completes
    chk("to_pre_flag", timeout_o, 0);
    results.delete();
    y_hold = 1;
    b0 = b_cnt;
    push(4'd7, 4'd14);
    push(4'd6, 4'd9);
    wait_b(b0);
    bt = b_t;
    y_hold = 0;
    wait_idle("to_idle", 300);
    chk("to_flag", timeout_o, 1);
    // WAIT_Y is entered the cycle after B; flag visible 64 cycles later
    chk("to_latency", to_t - bt, 65);
    chk("to_nres", results.size(), 1);
    if (results.size() > 0) chk("to_next_job", results[0], {4'd6, 4'd9, 4'd3});
    chk("to_done_cnt", done_cnt_o, 8);

    // Reset while in WAIT_Y with two jobs queued
    y_hold = 1;
    b0 = b_cnt;
    push(4'd1, 4'd2);
    push(4'd3, 4'd4);
    push(4'd5, 4'd6);
    wait_b(b0);
    repeat (2) tick();
    chk("rm_busy_before", busy_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rm_busy", busy_o, 0);
    chk("rm_cmd_ready", cmd_ready_o, 1);
    chk("rm_timeout", timeout_o, 0);
    chk("rm_done_cnt", done_cnt_o, 0);
    chk("rm_res_valid", res_valid_o, 0);
    chk("rm_res_y", res_y_o, 0);
    chk("rm_data", {a_data_o, b_data_o}, 0);
    repeat (2) tick();
    results.delete();
    y_hold = 0;
    rst_n  = 1'b1;
    repeat (10) tick();
    chk("rm_busy_after", busy_o, 0);
    chk("rm_no_stale", results.size(), 0);
    chk("rm_res_valid_after", res_valid_o, 0);

    // Done counter wrap
    results.delete();
    for (int i = 0; i < 256; i++) push(4'd6, 4'd9);
    wait_idle("wrap_idle", 200);
    chk("wrap_nres", results.size(), 256);
    chk("wrap_done_cnt_0", done_cnt_o, 0);
    push(4'd6, 4'd9);
    wait_idle("wrap_idle2", 50);
    chk("wrap_done_cnt_1", done_cnt_o, 1);

    chk("strobe_overlap", overlap, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
